// File: rtl/fifo_state_cal.sv
// fifo_state_cal: FIFO state register, head/tail pointers, occupancy count, register-file enables and status flags
module fifo_state_cal #(
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    next_state,
  output logic [2:0]    state,
  output logic [CW-1:0] data_count,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic          we,
  output logic          re,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
);
  typedef enum logic [2:0] {
    INIT = 3'b000, NO_OP = 3'b001, WRITE = 3'b010,
    WR_ERROR = 3'b011, READ = 3'b100, RD_ERROR = 3'b101
  } state_t;
  logic [2:0] ns_legal;
  logic do_wr, do_rd;
  // Unused encodings (and unknowns) collapse to NO_OP so nothing moves.
  always_comb begin
    ns_legal = NO_OP;
    case (next_state)
      INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR: ns_legal = next_state;
      default: ns_legal = NO_OP;
    endcase
  end
  assign do_wr = (next_state == WRITE) && (data_count < CW'(DEPTH));
  assign do_rd = (next_state == READ) && (data_count != '0);
  assign we    = do_wr && reset_n;
  assign re    = do_rd && reset_n;
  assign full  = data_count == CW'(DEPTH);
  assign empty = data_count == '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state      <= ns_legal;
      tail       <= do_wr ? tail + 1'b1 : tail;
      head       <= do_rd ? head + 1'b1 : head;
      data_count <= do_wr ? data_count + 1'b1 : do_rd ? data_count - 1'b1 : data_count;
      wr_ack     <= do_wr;
      rd_ack     <= do_rd;
      wr_err     <= ns_legal == WR_ERROR;
      rd_err     <= ns_legal == RD_ERROR;
    end
  end
endmodule

// File: tb/tb_fifo_state_cal.sv
// tb_fifo_state_cal: directed checks of fill, overflow, drain, interleave, illegal encoding and async reset
module tb_fifo_state_cal;
  logic clk = 0, reset_n = 0;
  logic [2:0] next_state = 3'b000;
  logic [2:0] state;
  logic [3:0] data_count;
  logic [2:0] head, tail;
  logic we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;
  int total = 0, bad = 0;
  fifo_state_cal dut (
    .clk(clk), .reset_n(reset_n), .next_state(next_state), .state(state),
    .data_count(data_count), .head(head), .tail(tail), .we(we), .re(re),
    .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] ns);
    next_state = ns;
    @(posedge clk);
    #1;
  endtask
  localparam logic [2:0] NOP = 3'b001, WR = 3'b010, WRE = 3'b011, RD = 3'b100, RDE = 3'b101;
  initial begin
    #2;
    chk("rst_state", state, 0); chk("rst_cnt", data_count, 0);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_we", we, 0); chk("rst_flags", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      next_state = WR; #1;
      chk("fill_we", we, 1);
      step(WR);
      chk("fill_tail", tail, (i + 1) % 8); chk("fill_cnt", data_count, i + 1);
      chk("fill_ack", wr_ack, 1); chk("fill_full", full, i == 7);
    end
    next_state = WR; #1;
    chk("ovf_we", we, 0);
    step(WR);
    chk("ovf_cnt", data_count, 8); chk("ovf_ack", wr_ack, 0);
    chk("ovf_tail", tail, 0); chk("ovf_state", state, 2);
    step(WRE);
    chk("wrerr_flag", wr_err, 1); chk("wrerr_state", state, 3); chk("wrerr_cnt", data_count, 8);
    for (int i = 0; i < 8; i++) begin
      next_state = RD; #1;
      chk("drain_re", re, 1);
      step(RD);
      chk("drain_head", head, (i + 1) % 8); chk("drain_cnt", data_count, 7 - i);
      chk("drain_ack", rd_ack, 1); chk("drain_empty", empty, i == 7);
    end
    next_state = RD; #1;
    chk("udf_re", re, 0);
    step(RD);
    chk("udf_cnt", data_count, 0); chk("udf_ack", rd_ack, 0); chk("udf_head", head, 0);
    step(RDE);
    chk("rderr_flag", rd_err, 1); chk("rderr_ack", rd_ack, 0); chk("rderr_state", state, 5);
    step(NOP);
    chk("rderr_drop", rd_err, 0);
    for (int i = 0; i < 3; i++) step(WR);
    chk("pre_cnt", data_count, 3); chk("pre_tail", tail, 3);
    for (int i = 0; i < 20; i++) begin
      step(i % 2 == 0 ? WR : RD);
      chk("il_cnt", data_count, i % 2 == 0 ? 4 : 3);
    end
    chk("il_head", head, 2); chk("il_tail", tail, 5);
    for (int i = 0; i < 3; i++) begin
      step(NOP);
      chk("nop_cnt", data_count, 3); chk("nop_ptrs", {head, tail}, {3'd2, 3'd5});
      chk("nop_state", state, 1); chk("nop_flags", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    end
    step(WR);
    chk("pre_ill_ack", wr_ack, 1);
    next_state = 3'b111; #1;
    chk("ill_we", {we, re}, 0);
    step(3'b111);
    chk("ill_state", state, 1); chk("ill_cnt", data_count, 4);
    chk("ill_ptrs", {head, tail}, {3'd2, 3'd6}); chk("ill_flags", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    step(3'b110);
    chk("ill110_state", state, 1); chk("ill110_cnt", data_count, 4);
    step(WR);
    chk("mid_cnt", data_count, 5); chk("mid_tail", tail, 7);
    #3;
    next_state = WR;
    reset_n = 0;
    #1;
    chk("arst_state", state, 0); chk("arst_ptrs", {head, tail}, 0);
    chk("arst_cnt", data_count, 0); chk("arst_empty", empty, 1);
    chk("arst_we_re", {we, re}, 0); chk("arst_ack", wr_ack, 0);
    @(negedge clk) reset_n = 1;
    step(WR);
    chk("post_cnt", data_count, 1); chk("post_tail", tail, 1); chk("post_ack", wr_ack, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
